// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: opcode constants, FSM states,
// buffer entry layout and the default reset PC.
package inst_fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   // Wide enough for outstanding/discard counts up to the largest legal buffer depth.
   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {
      RST   = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fetch_entry_t;

   function automatic logic inst_is_32b(input logic [31:0] inst);
      return inst[1:0] == 2'b11;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for the fetch buffer; push is accepted while full when a pop
// happens in the same cycle, and flush empties it in one cycle.
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: credit-limited request issue, in-order response buffering,
// redirect flush with discard of stale responses. Optional FETCH_ILLEGAL_DET_EN adds id_illegal.
//
// state | meaning
// RST   | first cycle after reset release, no request issued
// FETCH | normal operation, requests issued while buffer credit is available
// FLUSH | redirect taken with responses in flight; dropping them, no requests
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_inst,
   output logic [6:0]  id_opcode,
   output logic [31:0] id_pc
`ifdef FETCH_ILLEGAL_DET_EN
   ,
   output logic        id_illegal
`endif
);

   localparam int unsigned FCNT_W = $clog2(BUF_DEPTH + 1);
   localparam int unsigned OCC_W  = CNT_W + 1;

   fetch_state_e      state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0]  outst_q, outst_d;
   logic [CNT_W-1:0]  discard_q, discard_d;

   logic [FCNT_W-1:0] fifo_count;
   logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
   fetch_entry_t      fifo_wdata, fifo_rdata;

   logic [OCC_W-1:0]  occupancy;
   logic              req_c, grant, rsp_accept;
   logic [31:0]       redirect_tgt;

   assign occupancy    = OCC_W'(outst_q) + OCC_W'(fifo_count);
   assign redirect_tgt = {redirect_pc[31:2], 2'b00};
   // Responses with nothing outstanding are leftovers from before reset.
   assign rsp_accept   = imem_rvalid && (outst_q != '0);
   assign grant        = req_c && imem_gnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RST;
         pc_q      <= RESET_PC;
         rsp_pc_q  <= RESET_PC;
         outst_q   <= '0;
         discard_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         rsp_pc_q  <= rsp_pc_d;
         outst_q   <= outst_d;
         discard_q <= discard_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      rsp_pc_d   = rsp_pc_q;
      discard_d  = discard_q;
      req_c      = 1'b0;
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b0;

      case (state_q)
         RST:     state_d = FETCH;
         FETCH:   req_c = (occupancy < OCC_W'(BUF_DEPTH)) && !fifo_full;
         FLUSH:   req_c = 1'b0;
         default: state_d = RST;
      endcase

      outst_d = outst_q + CNT_W'(grant) - CNT_W'(rsp_accept);

      if (redirect_valid) begin
         // A grant in this cycle is already in flight, so it joins the discard count.
         fifo_flush = 1'b1;
         pc_d       = redirect_tgt;
         rsp_pc_d   = redirect_tgt;
         discard_d  = outst_d;
         state_d    = (outst_d != '0) ? FLUSH : FETCH;
      end else begin
         if (grant) pc_d = pc_q + 32'd4;
         if (rsp_accept) begin
            if (discard_q != '0) begin
               discard_d = discard_q - CNT_W'(1);
            end else begin
               fifo_push = 1'b1;
               rsp_pc_d  = rsp_pc_q + 32'd4;
            end
         end
         fifo_pop = !fifo_empty && id_ready;
         if (state_q == FLUSH && discard_d == '0) state_d = FETCH;
      end
   end

   assign fifo_wdata.inst = imem_rdata;
   assign fifo_wdata.pc   = rsp_pc_q;

   fetch_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH ($bits(fetch_entry_t)),
      .CNT_W (FCNT_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (fifo_flush),
      .push_i  (fifo_push),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign imem_req  = req_c;
   assign imem_addr = pc_q;
   assign id_valid  = !fifo_empty;
   assign id_inst   = fifo_empty ? 32'd0 : fifo_rdata.inst;
   assign id_pc     = fifo_empty ? 32'd0 : fifo_rdata.pc;
   assign id_opcode = id_inst[6:0];

`ifdef FETCH_ILLEGAL_DET_EN
   assign id_illegal = id_valid && !inst_is_32b(id_inst);
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: acts as the instruction memory and checks fetch
// addresses, decode stream order and buffer credit against a queue-based reference model.
module tb_inst_fetch;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int          BUF_DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_inst;
   logic [6:0]  id_opcode;
   logic [31:0] id_pc;
`ifdef FETCH_ILLEGAL_DET_EN
   logic        id_illegal;
`endif

   inst_fetch #(
      .RESET_PC  (RESET_PC),
      .BUF_DEPTH (BUF_DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_inst        (id_inst),
      .id_opcode      (id_opcode),
      .id_pc          (id_pc)
`ifdef FETCH_ILLEGAL_DET_EN
      ,
      .id_illegal     (id_illegal)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
      int          ep;
   } rsp_t;

   int          n_checks = 0;
   int          n_errors = 0;
   rsp_t        q[$];
   int          buffered;
   int          epoch;
   int          cyc;
   logic [31:0] fetch_pc;
   logic [31:0] dec_pc;
   logic        first;
   int          spur_cnt;

   int          gnt_pct, rv_pct, rdy_pct, redir_pm, lat_min, lat_max;
   logic        force_redir;
   logic [31:0] force_tgt;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0200) return 32'h0000_0001;
      if (a == 32'h0000_0204) return 32'h0000_0013;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic set_mode(input int g, input int rv, input int rdy, input int rd, input int lmin, input int lmax);
      gnt_pct = g; rv_pct = rv; rdy_pct = rdy; redir_pm = rd; lat_min = lmin; lat_max = lmax;
   endtask

   task automatic run_cycle();
      logic        exp_req, exp_valid, do_pop, do_grant, redir, rv_taken;
      logic [31:0] tgt, exp_inst;
      int          stale, lat;
      rsp_t        e;
      stale = 0;
      foreach (q[i]) if (q[i].ep != epoch) stale++;

      imem_gnt    = ($urandom_range(99) < gnt_pct);
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      rv_taken    = 1'b0;
      if (q.size() > 0) begin
         if (q[0].due <= cyc && $urandom_range(99) < rv_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(q[0].addr);
            rv_taken    = 1'b1;
         end
      end else if (spur_cnt > 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = 32'hDEAD_BEEF;
      end
      redir = !first && (force_redir || ($urandom_range(999) < redir_pm));
      if (force_redir) tgt = force_tgt;
      else if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      else tgt = $urandom & 32'h0000_0FFF;
      redirect_valid = redir;
      redirect_pc    = tgt;
      id_ready       = ($urandom_range(99) < rdy_pct);
      #1;

      exp_req   = !first && stale == 0 && (q.size() + buffered < BUF_DEPTH);
      exp_valid = (buffered != 0);
      exp_inst  = exp_valid ? mem_word(dec_pc) : 32'd0;
      check_val("imem_req", 32'(imem_req), 32'(exp_req));
      check_val("id_valid", 32'(id_valid), 32'(exp_valid));
      if (exp_req) check_val("imem_addr", imem_addr, fetch_pc);
      if (exp_valid) begin
         check_val("id_pc", id_pc, dec_pc);
         check_val("id_inst", id_inst, exp_inst);
         check_val("id_opcode", 32'(id_opcode), 32'(exp_inst[6:0]));
      end
`ifdef FETCH_ILLEGAL_DET_EN
      check_val("id_illegal", 32'(id_illegal), 32'(exp_valid && exp_inst[1:0] != 2'b11));
`endif

      do_pop   = exp_valid && id_ready && !redir;
      do_grant = exp_req && imem_gnt;
      if (rv_taken) begin
         e = q.pop_front();
         if (e.ep == epoch) buffered++;
      end
      if (do_pop) begin
         buffered--;
         dec_pc += 32'd4;
      end
      if (do_grant) begin
         lat = int'($urandom_range(lat_max, lat_min));
         q.push_back('{fetch_pc, cyc + 1 + lat, epoch});
         fetch_pc += 32'd4;
      end
      if (redir) begin
         epoch++;
         buffered = 0;
         fetch_pc = {tgt[31:2], 2'b00};
         dec_pc   = fetch_pc;
      end
      force_redir = 1'b0;
      first       = 1'b0;
      if (spur_cnt > 0) spur_cnt--;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   // Reset asserted asynchronously mid-cycle; the memory abandons everything in flight.
   task automatic do_reset();
      imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0; id_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_val("rst_imem_req", 32'(imem_req), 32'd0);
      check_val("rst_imem_addr", imem_addr, RESET_PC);
      check_val("rst_id_valid", 32'(id_valid), 32'd0);
      check_val("rst_id_inst", id_inst, 32'd0);
      check_val("rst_id_opcode", 32'(id_opcode), 32'd0);
      check_val("rst_id_pc", id_pc, 32'd0);
`ifdef FETCH_ILLEGAL_DET_EN
      check_val("rst_id_illegal", 32'(id_illegal), 32'd0);
`endif
      q.delete();
      buffered = 0;
      epoch++;
      fetch_pc = RESET_PC;
      dec_pc   = RESET_PC;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      first    = 1'b1;
      spur_cnt = 2;
   endtask

   initial begin
      buffered = 0; epoch = 0; cyc = 0; first = 1'b1; spur_cnt = 0;
      fetch_pc = RESET_PC; dec_pc = RESET_PC;
      force_redir = 1'b0; force_tgt = '0;
      set_mode(100, 100, 100, 0, 0, 0);
      @(posedge clk);
      do_reset();

      // Back-to-back fetch from reset with single-cycle memory latency
      run_cycles(20);

      // Decode stall, then release
      set_mode(100, 100, 0, 0, 0, 0);
      run_cycles(6);
      set_mode(100, 100, 100, 0, 0, 0);
      run_cycles(10);

      // Redirect with two responses in flight
      set_mode(100, 100, 100, 0, 3, 3);
      for (int i = 0; i < 50; i++) begin
         if (q.size() == 2 && buffered == 0) break;
         run_cycle();
      end
      check_val("wait_2_outstanding", 32'(q.size()), 32'd2);
      force_redir = 1'b1;
      force_tgt   = 32'h0000_0102;
      run_cycle();
      check_val("flush_no_req", 32'(imem_req), 32'd0);
      run_cycles(20);

      // Address wrap at the top of the address space
      set_mode(100, 100, 100, 0, 0, 1);
      force_redir = 1'b1;
      force_tgt   = 32'hFFFF_FFF8;
      run_cycles(20);

      // Compressed-looking and normal encodings at the decode port
      force_redir = 1'b1;
      force_tgt   = 32'h0000_0200;
      run_cycles(12);

      // Random traffic with redirects, stalls and variable latency
      set_mode(70, 70, 60, 30, 0, 3);
      run_cycles(3000);

      // Reset with one response in flight
      set_mode(100, 100, 0, 0, 4, 4);
      for (int i = 0; i < 50; i++) begin
         if (q.size() == 1) break;
         run_cycle();
      end
      check_val("wait_1_outstanding", 32'(q.size()), 32'd1);
      do_reset();
      set_mode(100, 100, 100, 0, 0, 0);
      run_cycles(20);
      set_mode(60, 80, 70, 20, 0, 2);
      run_cycles(500);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
